// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a host-loaded melody from a small note RAM into a DDS frequency word
// Ports:
//   iCLK, iRST              system clock, asynchronous active-high reset
//   iLRCK                   DAC LR clock (async); each falling edge is one sample tick
//   iWR_EN/ADDR/FREQ/DUR    note RAM write port ({freq Hz, duration in ticks})
//   iLAST_ADDR, iLOOP       final note index (sampled at start), wrap-to-0 enable
//   iSTART, iSTOP           start / stop pulses (stop wins)
//   iOCTAVE                 octave shift applied at fetch, only with TONE_SEQ_TRANSPOSE_EN defined
//   oFREQ, oGATE            DDS frequency word and note-sounding gate
//   oNOTE_IDX, oBUSY, oDONE current note, not-idle flag, natural-finish pulse
module tone_sequencer #(
  parameter int AW = 4,
  parameter int DUR_W = 16,
  parameter int GAP_TICKS = 64
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iLRCK,
  input  logic             iWR_EN,
  input  logic [AW-1:0]    iWR_ADDR,
  input  logic [31:0]      iWR_FREQ,
  input  logic [DUR_W-1:0] iWR_DUR,
  input  logic [AW-1:0]    iLAST_ADDR,
  input  logic             iLOOP,
  input  logic             iSTART,
  input  logic             iSTOP,
`ifdef TONE_SEQ_TRANSPOSE_EN
  input  logic [1:0]       iOCTAVE,
`endif
  output logic [31:0]      oFREQ,
  output logic             oGATE,
  output logic [AW-1:0]    oNOTE_IDX,
  output logic             oBUSY,
  output logic             oDONE
);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int CW = DUR_W > GW ? DUR_W : GW;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;
  state_t           state_q;
  logic [31:0]      mem_f [2**AW];
  logic [DUR_W-1:0] mem_d [2**AW];
  logic [31:0]      rd_f_q;
  logic [DUR_W-1:0] rd_d_q;
  logic [AW-1:0]    addr_q, addr_d, last_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       sync_q;
  logic             edge_q, tick_q;
  logic [31:0]      fetch_f;
  logic             start_ok, stop_ok, adv, more;
  always_comb begin
    start_ok = state_q == S_IDLE && iSTART && !iSTOP;
    stop_ok = state_q != S_IDLE && iSTOP;
    more = addr_q < last_q || iLOOP;
    adv = tick_q && cnt_q == CW'(1) && !iSTOP &&
          (state_q == S_GAP || (state_q == S_PLAY && GAP_TICKS == 0));
    // RAM is read with the next address so the data is ready in FETCH
    addr_d = start_ok ? '0 : (adv && more) ? (addr_q < last_q ? addr_q + 1'b1 : '0) : addr_q;
`ifdef TONE_SEQ_TRANSPOSE_EN
    fetch_f = rd_f_q << iOCTAVE;
`else
    fetch_f = rd_f_q;
`endif
  end
  assign oBUSY = state_q != S_IDLE;
  always_ff @(posedge iCLK) begin
    if (iWR_EN) begin
      mem_f[iWR_ADDR] <= iWR_FREQ;
      mem_d[iWR_ADDR] <= iWR_DUR;
    end
    rd_f_q <= mem_f[addr_d];
    rd_d_q <= mem_d[addr_d];
  end
  // two-flop synchroniser plus edge register; tick is a registered falling-edge pulse
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], iLRCK};
      edge_q <= sync_q[1];
      tick_q <= edge_q & ~sync_q[1];
    end
  end
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      last_q <= '0;
      cnt_q <= '0;
      oFREQ <= '0;
      oGATE <= 1'b0;
      oNOTE_IDX <= '0;
      oDONE <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      addr_q <= addr_d;
      if (stop_ok) begin
        state_q <= S_IDLE;
        oFREQ <= '0;
        oGATE <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (start_ok) begin
            last_q <= iLAST_ADDR;
            state_q <= S_FETCH;
          end
          S_FETCH: begin
            oFREQ <= fetch_f;
            oGATE <= |rd_f_q;
            oNOTE_IDX <= addr_q;
            cnt_q <= rd_d_q == '0 ? CW'(1) : CW'(rd_d_q);
            state_q <= S_PLAY;
          end
          S_PLAY: if (tick_q) begin
            if (cnt_q != CW'(1)) cnt_q <= cnt_q - 1'b1;
            else begin
              oFREQ <= '0;
              oGATE <= 1'b0;
              if (GAP_TICKS > 0) begin
                cnt_q <= CW'(GAP_TICKS);
                state_q <= S_GAP;
              end else begin
                state_q <= more ? S_FETCH : S_IDLE;
                oDONE <= !more;
              end
            end
          end
          default: if (tick_q) begin
            if (cnt_q != CW'(1)) cnt_q <= cnt_q - 1'b1;
            else begin
              state_q <= more ? S_FETCH : S_IDLE;
              oDONE <= !more;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: randomized check of two tone_sequencer instances (no gap, 2-tick gap) against a slot-list model
module tb_tone_sequencer;
  logic clk = 0, rst = 1, lrck = 1, wr_en = 0, loop_i = 0, start = 0, stop = 0;
  logic [3:0] wr_addr = 0, last = 0;
  logic [31:0] wr_freq = 0;
  logic [15:0] wr_dur = 0;
  logic [1:0] oct = 0;
  logic [31:0] fa, fb;
  logic ga, gb, ba, bb, da, db;
  logic [3:0] ia, ib;
  int n_vec = 0, n_err = 0, nda = 0, ndb = 0;
  logic [31:0] ram_f [16];
  logic [15:0] ram_d [16];
  typedef struct {logic [31:0] f; logic g; logic [3:0] i;} slot_t;
  slot_t qa[$], qb[$];
  slot_t idle_s = '{32'd0, 1'b0, 4'd0};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (da) nda <= nda + 1;
    if (db) ndb <= ndb + 1;
  end
  tone_sequencer #(.AW(4), .DUR_W(16), .GAP_TICKS(0)) ua (
    .iCLK(clk), .iRST(rst), .iLRCK(lrck), .iWR_EN(wr_en), .iWR_ADDR(wr_addr),
    .iWR_FREQ(wr_freq), .iWR_DUR(wr_dur), .iLAST_ADDR(last), .iLOOP(loop_i),
    .iSTART(start), .iSTOP(stop),
`ifdef TONE_SEQ_TRANSPOSE_EN
    .iOCTAVE(oct),
`endif
    .oFREQ(fa), .oGATE(ga), .oNOTE_IDX(ia), .oBUSY(ba), .oDONE(da));
  tone_sequencer #(.AW(4), .DUR_W(16), .GAP_TICKS(2)) ub (
    .iCLK(clk), .iRST(rst), .iLRCK(lrck), .iWR_EN(wr_en), .iWR_ADDR(wr_addr),
    .iWR_FREQ(wr_freq), .iWR_DUR(wr_dur), .iLAST_ADDR(last), .iLOOP(loop_i),
    .iSTART(start), .iSTOP(stop),
`ifdef TONE_SEQ_TRANSPOSE_EN
    .iOCTAVE(oct),
`endif
    .oFREQ(fb), .oGATE(gb), .oNOTE_IDX(ib), .oBUSY(bb), .oDONE(db));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cmp(input string p, input bit live, input slot_t s, input logic [31:0] f,
                     input logic g, input logic [3:0] i, input logic b);
    chk({p, "_busy"}, 32'(b), 32'(live));
    chk({p, "_freq"}, f, live ? s.f : 32'd0);
    chk({p, "_gate"}, 32'(g), 32'(live && s.g));
    if (live) chk({p, "_idx"}, 32'(i), 32'(s.i));
  endtask
  task automatic wr(input int a, input logic [31:0] f, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = 4'(a); wr_freq = f; wr_dur = d;
    ram_f[a] = f; ram_d[a] = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic tick();
    repeat (2) @(negedge clk);
    lrck = 1;
    repeat (10) @(negedge clk);
    lrck = 0;
    repeat (8) @(negedge clk);
  endtask
  // expected outputs after each tick: one slot per tick of note, then gap ticks
  task automatic build(input int lst, input bit lp, input int cap);
    int idx, d;
    logic [31:0] f;
    idx = 0;
    qa.delete(); qb.delete();
    forever begin
      f = ram_f[idx] << oct;
      d = ram_d[idx] == 0 ? 1 : int'(ram_d[idx]);
      repeat (d) begin
        qa.push_back('{f, ram_f[idx] != 0, 4'(idx)});
        qb.push_back('{f, ram_f[idx] != 0, 4'(idx)});
      end
      repeat (2) qb.push_back('{32'd0, 1'b0, 4'(idx)});
      if (idx < lst) idx++;
      else if (lp && qa.size() < cap) idx = 0;
      else break;
    end
  endtask
  task automatic run(input int lst, input bit lp, input int stop_at, input bit wr0);
    int na0, nb0, n;
    bit stopped;
    na0 = nda; nb0 = ndb; stopped = 0;
    build(lst, lp, 60);
    n = lp ? 1000 : qb.size() + 1;
    @(negedge clk);
    last = 4'(lst); loop_i = lp; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    cmp("a0", 1, qa[0], fa, ga, ia, ba);
    cmp("b0", 1, qb[0], fb, gb, ib, bb);
    if (wr0) wr(0, $urandom, 16'($urandom_range(0, 3)));
    for (int k = 1; k <= n && !stopped; k++) begin
      tick();
      if (k == stop_at) begin
        @(negedge clk) stop = 1;
        @(negedge clk) stop = 0;
        cmp("a_stop", 0, idle_s, fa, ga, ia, ba);
        cmp("b_stop", 0, idle_s, fb, gb, ib, bb);
        stopped = 1;
      end else begin
        cmp("a", k < qa.size(), k < qa.size() ? qa[k] : idle_s, fa, ga, ia, ba);
        cmp("b", k < qb.size(), k < qb.size() ? qb[k] : idle_s, fb, gb, ib, bb);
      end
    end
    chk("a_done", 32'(nda - na0), 32'(!lp && (stop_at == 0 || stop_at >= qa.size())));
    chk("b_done", 32'(ndb - nb0), 32'(!lp && (stop_at == 0 || stop_at >= qb.size())));
  endtask
  initial begin
    int lp;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({ba, bb}), 0);
    chk("rst_freq", fa | fb, 0);
    chk("rst_gate", 32'({ga, gb}), 0);
    chk("rst_idx", 32'({ia, ib}), 0);
    chk("rst_done", 32'({da, db}), 0);
    rst = 0;
    for (int i = 0; i < 16; i++) wr(i, 0, 0);
    wr(0, 440, 4); wr(1, 0, 2); wr(2, 880, 3);
    run(2, 0, 0, 0);
    run(2, 1, 7, 0);
    run(2, 1, 20, 0);
    wr(0, 1000, 0);
    run(1, 0, 0, 1);
    @(negedge clk) last = 2; loop_i = 1; start = 1;
    @(negedge clk) start = 0;
    tick(); tick();
    rst = 1;
    #1;
    chk("mrst_busy", 32'({ba, bb}), 0);
    chk("mrst_freq", fa | fb, 0);
    chk("mrst_gate", 32'({ga, gb}), 0);
    chk("mrst_idx", 32'({ia, ib}), 0);
    @(negedge clk) rst = 0;
    tick();
    chk("post_rst_busy", 32'({ba, bb}), 0);
    @(negedge clk) start = 1; stop = 1;
    @(negedge clk) start = 0; stop = 0;
    @(negedge clk);
    chk("ss_busy", 32'({ba, bb}), 0);
    chk("ss_freq", fa | fb, 0);
    chk("ss_gate", 32'({ga, gb}), 0);
`ifdef TONE_SEQ_TRANSPOSE_EN
    oct = 2; wr(0, 440, 1); run(0, 0, 0, 0);
    oct = 1; wr(0, 32'h8000_0001, 1); run(0, 0, 0, 0);
`endif
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) wr(i, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom, 16'($urandom_range(0, 3)));
`ifdef TONE_SEQ_TRANSPOSE_EN
      oct = 2'($urandom);
`endif
      lp = $urandom_range(0, 1);
      run($urandom_range(0, 15), lp[0], lp ? $urandom_range(1, 40) : ($urandom_range(0, 1) ? $urandom_range(1, 30) : 0), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
